idu_is_pipe4_iq: RTL
====================

Name: idu_is_pipe4_iq

Overview:
- Issue queue for execution pipe 4, sitting directly upstream of the pipe-4 register-read stage.
- Accepts dispatched single-source instructions (opcode, psrc1, imm) and tracks psrc1 readiness by snooping the EX and CDB writeback tags.
- Each cycle, issues the oldest ready entry on the idu_idu_rf_pipe4_* interface, which the register-read stage registers.
- The queue is compacting: entry 0 is always the oldest.

Parameters:
- DEPTH, 8, number of queue entries (power of two not required, minimum 2)
- IID_W, 5, instruction ID width
- PREG_W, 6, physical register tag width
- OPC_W, 7, opcode width
- IMM_W, 64, immediate width

Ports:
- clk  in  1  clock
- rst_clk  in  1  asynchronous active-low reset
- rtu_global_flush  in  1  pipeline flush
- dis_pipe4_vld  in  1  dispatch request
- dis_pipe4_iid  in  IID_W  instruction ID
- dis_pipe4_opcode  in  OPC_W  opcode
- dis_pipe4_psrc1_vld  in  1  instruction has a register source
- dis_pipe4_psrc1  in  PREG_W  source physical register
- dis_pipe4_psrc1_rdy  in  1  source already available at dispatch
- dis_pipe4_imm_vld  in  1  immediate valid
- dis_pipe4_imm  in  IMM_W  immediate
- iq_pipe4_full  out  1  queue full; dispatch must not be asserted
- iq_pipe4_entry_cnt  out  $clog2(DEPTH+1)  occupied entries
- exu_idu_is_{alu,mxu,div,lsu}_ex_vld  in  1 each  EX-stage writeback tag valid
- exu_idu_is_{alu,mxu,div,lsu}_ex_preg  in  PREG_W each  EX-stage writeback tag
- exu_idu_is_{alu,mxu,div,lsu}_cdb_vld  in  1 each  CDB writeback tag valid
- exu_idu_is_{alu,mxu,div,lsu}_cdb_preg  in  PREG_W each  CDB writeback tag
- idu_idu_rf_pipe4_vld  out  1  issue valid
- idu_idu_rf_pipe4_iid  out  IID_W  issued instruction ID
- idu_idu_rf_pipe4_opcode  out  OPC_W  issued opcode
- idu_idu_rf_pipe4_psrc1_vld  out  1  issued source valid
- idu_idu_rf_pipe4_psrc1  out  PREG_W  issued source tag
- idu_idu_rf_pipe4_imm_vld  out  1  issued immediate valid
- idu_idu_rf_pipe4_imm  out  IMM_W  issued immediate

Behaviour:
- Reset: rst_clk is asynchronous, active-low; clock is clk. On reset, all entry valid and ready bits clear and count = 0.
  - Outputs after reset: all idu_idu_rf_pipe4_* = 0, iq_pipe4_full = 0, entry_cnt = 0.
- Entry state: valid, rdy, iid, opcode, psrc1_vld, psrc1, imm_vld, imm.
- Wakeup match: entry with valid & psrc1_vld & !rdy sets rdy at the next edge if any of the 8 tag buses is valid with preg == psrc1.
  - EX tags and CDB tags have equal priority.
  - Register-read forwarding covers the value.
- Dispatch:
  - Entry written at index count, or count-1 if an issue happens in the same cycle.
  - rdy is written as dis_pipe4_psrc1_rdy | !dis_pipe4_psrc1_vld | (same-cycle wakeup tag match on dis_pipe4_psrc1).
  - Minimum latency dispatch→issue is 1 cycle; there is no bypass path.
- Select: combinational; lowest index with valid & rdy. Outputs are driven from that entry with idu_idu_rf_pipe4_vld = 1.
  - If no entry is ready, vld = 0 and all payload outputs = 0.
- Issue: the selected entry is removed at the next edge. Entries above it shift down one index, keeping their rdy and any same-cycle wakeup.
- Count update: count_next = count + dispatch − issue.
- Full: iq_pipe4_full = (count == DEPTH), combinational from registered count. No same-cycle issue credit is given.
  - Dispatch while full is a protocol violation. It is ignored (no write, count unchanged); a simulation assertion flags it.
- Flush: rtu_global_flush has priority over everything.
  - Same cycle: idu_idu_rf_pipe4_vld is forced to 0 and payload to 0.
  - Next edge: all entries invalidate and count = 0; a concurrent dispatch is dropped.
- Flush and reset mid-operation have the same end state.
- Simultaneous dispatch + issue at count == DEPTH cannot occur (full blocks dispatch).
- Simultaneous dispatch + issue at count == 1 leaves count = 1, with the new entry at index 0.

Decomposition:
- Shared package idu_pkg:
  - PREG_W, IID_W, OPC_W constants
  - wakeup-bus count (8)
  - typedef of the IQ entry struct
- One natural sub-module: idu_is_iq_entry. It holds one entry's registers and wakeup compare, and takes shift-in / write / clear controls. It is instantiated DEPTH times under a generate loop.
- Select and shift control stay in the top level.

Test Plan:
1. Reset, then dispatch iid=3, psrc1_vld=0, imm=0x10 → one cycle later vld=1, iid=3, imm=0x10; next cycle vld=0, count=0.
2. Dispatch iid=1 with psrc1=12 not ready, then iid=2 ready → iid=2 issues first. Drive cdb_alu_vld with preg=12 → iid=1 issues the following cycle.
3. Dispatch iid=5 with psrc1=7 in the same cycle as ex_mxu_vld preg=7 → iid=5 issues next cycle (captured wakeup).
4. Fill 8 entries with psrc1=20 not ready → full=1, count=8. Dispatch attempt ignored. lsu_cdb preg=20 → entries issue in dispatch order, one per cycle, for 8 cycles; full drops after the first issue.
5. Occupy 5 entries with 2 ready; assert flush with a concurrent dispatch → vld=0 that cycle; next cycle count=0 and no issue. A ready dispatch afterward issues normally.
6. With 3 entries, assert rst_clk low asynchronously mid-cycle → all outputs 0 immediately; count=0 after release.

Source files
------------

// File: rtl/idu_pkg.sv
// Shared IDU constants and types for the issue-stage queues.
// Tag buses are four EX writeback tags followed by four CDB tags.
package idu_pkg;

    localparam int unsigned IID_W  = 5;
    localparam int unsigned PREG_W = 6;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned IMM_W  = 64;
    localparam int unsigned WAKE_N = 8;

    typedef struct packed {
        logic              valid;
        logic              rdy;
        logic [IID_W-1:0]  iid;
        logic [OPC_W-1:0]  opcode;
        logic              psrc1_vld;
        logic [PREG_W-1:0] psrc1;
        logic              imm_vld;
        logic [IMM_W-1:0]  imm;
    } iq_entry_t;

endpackage

// File: rtl/idu_is_iq_entry.sv
// One issue-queue slot: payload registers plus psrc1 wakeup compare.
// Priority per edge: flush, dispatch write, shift-in from the slot above, hold.
module idu_is_iq_entry
    import idu_pkg::WAKE_N;
#(
    parameter int unsigned IID_W  = idu_pkg::IID_W,
    parameter int unsigned PREG_W = idu_pkg::PREG_W,
    parameter int unsigned OPC_W  = idu_pkg::OPC_W,
    parameter int unsigned IMM_W  = idu_pkg::IMM_W
) (
    input  logic                     clk,
    input  logic                     rst_clk,
    input  logic                     flush,
    input  logic [WAKE_N-1:0]        wake_vld,
    input  logic [WAKE_N*PREG_W-1:0] wake_preg,
    input  logic                     write,
    input  logic                     wr_rdy,
    input  logic [IID_W-1:0]         wr_iid,
    input  logic [OPC_W-1:0]         wr_opcode,
    input  logic                     wr_psrc1_vld,
    input  logic [PREG_W-1:0]        wr_psrc1,
    input  logic                     wr_imm_vld,
    input  logic [IMM_W-1:0]         wr_imm,
    input  logic                     shift_in,
    input  logic                     up_valid,
    input  logic                     up_rdy,
    input  logic [IID_W-1:0]         up_iid,
    input  logic [OPC_W-1:0]         up_opcode,
    input  logic                     up_psrc1_vld,
    input  logic [PREG_W-1:0]        up_psrc1,
    input  logic                     up_imm_vld,
    input  logic [IMM_W-1:0]         up_imm,
    output logic                     valid,
    output logic                     rdy,
    output logic                     rdy_upd,
    output logic [IID_W-1:0]         iid,
    output logic [OPC_W-1:0]         opcode,
    output logic                     psrc1_vld,
    output logic [PREG_W-1:0]        psrc1,
    output logic                     imm_vld,
    output logic [IMM_W-1:0]         imm
);

    logic              valid_q;
    logic              rdy_q;
    logic [IID_W-1:0]  iid_q;
    logic [OPC_W-1:0]  opcode_q;
    logic              psrc1_vld_q;
    logic [PREG_W-1:0] psrc1_q;
    logic              imm_vld_q;
    logic [IMM_W-1:0]  imm_q;
    logic              hit;

    always_comb begin
        hit = 1'b0;
        for (int b = 0; b < WAKE_N; b++) begin
            if (wake_vld[b] && (wake_preg[b*PREG_W +: PREG_W] == psrc1_q)) begin
                hit = 1'b1;
            end
        end
    end

    // Ready including this cycle's wakeup; the slot below takes this when shifting.
    assign rdy_upd = rdy_q | (valid_q & psrc1_vld_q & hit);

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            valid_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else if (write) begin
            valid_q <= 1'b1;
            rdy_q   <= wr_rdy;
        end else if (shift_in) begin
            valid_q <= up_valid;
            rdy_q   <= up_rdy;
        end else begin
            rdy_q   <= rdy_upd;
        end
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            iid_q       <= '0;
            opcode_q    <= '0;
            psrc1_vld_q <= 1'b0;
            psrc1_q     <= '0;
            imm_vld_q   <= 1'b0;
            imm_q       <= '0;
        end else if (write) begin
            iid_q       <= wr_iid;
            opcode_q    <= wr_opcode;
            psrc1_vld_q <= wr_psrc1_vld;
            psrc1_q     <= wr_psrc1;
            imm_vld_q   <= wr_imm_vld;
            imm_q       <= wr_imm;
        end else if (shift_in) begin
            iid_q       <= up_iid;
            opcode_q    <= up_opcode;
            psrc1_vld_q <= up_psrc1_vld;
            psrc1_q     <= up_psrc1;
            imm_vld_q   <= up_imm_vld;
            imm_q       <= up_imm;
        end
    end

    assign valid     = valid_q;
    assign rdy       = rdy_q;
    assign iid       = iid_q;
    assign opcode    = opcode_q;
    assign psrc1_vld = psrc1_vld_q;
    assign psrc1     = psrc1_q;
    assign imm_vld   = imm_vld_q;
    assign imm       = imm_q;

endmodule

// File: rtl/idu_is_pipe4_iq.sv
// Compacting issue queue for execution pipe 4; entry 0 is always the oldest.
// Issues the oldest ready entry each cycle to the pipe-4 register-read stage.
module idu_is_pipe4_iq
    import idu_pkg::WAKE_N;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned IID_W  = idu_pkg::IID_W,
    parameter int unsigned PREG_W = idu_pkg::PREG_W,
    parameter int unsigned OPC_W  = idu_pkg::OPC_W,
    parameter int unsigned IMM_W  = idu_pkg::IMM_W
) (
    input  logic                         clk,
    input  logic                         rst_clk,
    input  logic                         rtu_global_flush,
    input  logic                         dis_pipe4_vld,
    input  logic [IID_W-1:0]             dis_pipe4_iid,
    input  logic [OPC_W-1:0]             dis_pipe4_opcode,
    input  logic                         dis_pipe4_psrc1_vld,
    input  logic [PREG_W-1:0]            dis_pipe4_psrc1,
    input  logic                         dis_pipe4_psrc1_rdy,
    input  logic                         dis_pipe4_imm_vld,
    input  logic [IMM_W-1:0]             dis_pipe4_imm,
    output logic                         iq_pipe4_full,
    output logic [$clog2(DEPTH+1)-1:0]   iq_pipe4_entry_cnt,
    input  logic                         exu_idu_is_alu_ex_vld,
    input  logic [PREG_W-1:0]            exu_idu_is_alu_ex_preg,
    input  logic                         exu_idu_is_mxu_ex_vld,
    input  logic [PREG_W-1:0]            exu_idu_is_mxu_ex_preg,
    input  logic                         exu_idu_is_div_ex_vld,
    input  logic [PREG_W-1:0]            exu_idu_is_div_ex_preg,
    input  logic                         exu_idu_is_lsu_ex_vld,
    input  logic [PREG_W-1:0]            exu_idu_is_lsu_ex_preg,
    input  logic                         exu_idu_is_alu_cdb_vld,
    input  logic [PREG_W-1:0]            exu_idu_is_alu_cdb_preg,
    input  logic                         exu_idu_is_mxu_cdb_vld,
    input  logic [PREG_W-1:0]            exu_idu_is_mxu_cdb_preg,
    input  logic                         exu_idu_is_div_cdb_vld,
    input  logic [PREG_W-1:0]            exu_idu_is_div_cdb_preg,
    input  logic                         exu_idu_is_lsu_cdb_vld,
    input  logic [PREG_W-1:0]            exu_idu_is_lsu_cdb_preg,
    output logic                         idu_idu_rf_pipe4_vld,
    output logic [IID_W-1:0]             idu_idu_rf_pipe4_iid,
    output logic [OPC_W-1:0]             idu_idu_rf_pipe4_opcode,
    output logic                         idu_idu_rf_pipe4_psrc1_vld,
    output logic [PREG_W-1:0]            idu_idu_rf_pipe4_psrc1,
    output logic                         idu_idu_rf_pipe4_imm_vld,
    output logic [IMM_W-1:0]             idu_idu_rf_pipe4_imm
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WAKE_N-1:0]        wake_vld;
    logic [WAKE_N*PREG_W-1:0] wake_preg;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_idx;
    logic             dis_hit;
    logic             dis_rdy;
    logic             dis_acc;
    logic             sel_vld;
    logic [IDX_W-1:0] sel_idx;
    logic             issue;
    logic [DEPTH-1:0] wr_en;
    logic [DEPTH-1:0] shift;

    logic [DEPTH-1:0]  e_valid;
    logic [DEPTH-1:0]  e_rdy;
    logic              e_rdy_upd   [DEPTH];
    logic [IID_W-1:0]  e_iid       [DEPTH];
    logic [OPC_W-1:0]  e_opcode    [DEPTH];
    logic              e_psrc1_vld [DEPTH];
    logic [PREG_W-1:0] e_psrc1     [DEPTH];
    logic              e_imm_vld   [DEPTH];
    logic [IMM_W-1:0]  e_imm       [DEPTH];

    assign wake_vld  = {exu_idu_is_lsu_cdb_vld, exu_idu_is_div_cdb_vld,
                        exu_idu_is_mxu_cdb_vld, exu_idu_is_alu_cdb_vld,
                        exu_idu_is_lsu_ex_vld,  exu_idu_is_div_ex_vld,
                        exu_idu_is_mxu_ex_vld,  exu_idu_is_alu_ex_vld};
    assign wake_preg = {exu_idu_is_lsu_cdb_preg, exu_idu_is_div_cdb_preg,
                        exu_idu_is_mxu_cdb_preg, exu_idu_is_alu_cdb_preg,
                        exu_idu_is_lsu_ex_preg,  exu_idu_is_div_ex_preg,
                        exu_idu_is_mxu_ex_preg,  exu_idu_is_alu_ex_preg};

    // Catch a tag broadcast in the dispatch cycle so the new entry is not left waiting.
    always_comb begin
        dis_hit = 1'b0;
        for (int b = 0; b < WAKE_N; b++) begin
            if (wake_vld[b] && (wake_preg[b*PREG_W +: PREG_W] == dis_pipe4_psrc1)) begin
                dis_hit = 1'b1;
            end
        end
    end

    assign dis_rdy       = dis_pipe4_psrc1_rdy | ~dis_pipe4_psrc1_vld | dis_hit;
    assign iq_pipe4_full = (count_q == CNT_W'(DEPTH));
    assign dis_acc       = dis_pipe4_vld & ~iq_pipe4_full & ~rtu_global_flush;

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (e_valid[i] && e_rdy[i]) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign issue  = sel_vld & ~rtu_global_flush;
    assign wr_idx = count_q - CNT_W'(issue);

    // Slots at and above the issued one pull from their upper neighbour; a write wins.
    always_comb begin
        wr_en = '0;
        shift = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en[i] = dis_acc && (wr_idx == CNT_W'(i));
            shift[i] = issue && (CNT_W'(i) >= CNT_W'(sel_idx));
        end
    end

    always_comb begin
        count_d = count_q + CNT_W'(dis_acc) - CNT_W'(issue);
        if (rtu_global_flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign iq_pipe4_entry_cnt = count_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic              up_valid;
        logic              up_rdy;
        logic [IID_W-1:0]  up_iid;
        logic [OPC_W-1:0]  up_opcode;
        logic              up_psrc1_vld;
        logic [PREG_W-1:0] up_psrc1;
        logic              up_imm_vld;
        logic [IMM_W-1:0]  up_imm;

        if (i < DEPTH - 1) begin : g_up
            assign up_valid     = e_valid[i+1];
            assign up_rdy       = e_rdy_upd[i+1];
            assign up_iid       = e_iid[i+1];
            assign up_opcode    = e_opcode[i+1];
            assign up_psrc1_vld = e_psrc1_vld[i+1];
            assign up_psrc1     = e_psrc1[i+1];
            assign up_imm_vld   = e_imm_vld[i+1];
            assign up_imm       = e_imm[i+1];
        end else begin : g_top
            assign up_valid     = 1'b0;
            assign up_rdy       = 1'b0;
            assign up_iid       = '0;
            assign up_opcode    = '0;
            assign up_psrc1_vld = 1'b0;
            assign up_psrc1     = '0;
            assign up_imm_vld   = 1'b0;
            assign up_imm       = '0;
        end

        idu_is_iq_entry #(
            .IID_W  (IID_W),
            .PREG_W (PREG_W),
            .OPC_W  (OPC_W),
            .IMM_W  (IMM_W)
        ) u_entry (
            .clk          (clk),
            .rst_clk      (rst_clk),
            .flush        (rtu_global_flush),
            .wake_vld     (wake_vld),
            .wake_preg    (wake_preg),
            .write        (wr_en[i]),
            .wr_rdy       (dis_rdy),
            .wr_iid       (dis_pipe4_iid),
            .wr_opcode    (dis_pipe4_opcode),
            .wr_psrc1_vld (dis_pipe4_psrc1_vld),
            .wr_psrc1     (dis_pipe4_psrc1),
            .wr_imm_vld   (dis_pipe4_imm_vld),
            .wr_imm       (dis_pipe4_imm),
            .shift_in     (shift[i]),
            .up_valid     (up_valid),
            .up_rdy       (up_rdy),
            .up_iid       (up_iid),
            .up_opcode    (up_opcode),
            .up_psrc1_vld (up_psrc1_vld),
            .up_psrc1     (up_psrc1),
            .up_imm_vld   (up_imm_vld),
            .up_imm       (up_imm),
            .valid        (e_valid[i]),
            .rdy          (e_rdy[i]),
            .rdy_upd      (e_rdy_upd[i]),
            .iid          (e_iid[i]),
            .opcode       (e_opcode[i]),
            .psrc1_vld    (e_psrc1_vld[i]),
            .psrc1        (e_psrc1[i]),
            .imm_vld      (e_imm_vld[i]),
            .imm          (e_imm[i])
        );
    end

    always_comb begin
        idu_idu_rf_pipe4_vld       = 1'b0;
        idu_idu_rf_pipe4_iid       = '0;
        idu_idu_rf_pipe4_opcode    = '0;
        idu_idu_rf_pipe4_psrc1_vld = 1'b0;
        idu_idu_rf_pipe4_psrc1     = '0;
        idu_idu_rf_pipe4_imm_vld   = 1'b0;
        idu_idu_rf_pipe4_imm       = '0;
        if (issue) begin
            idu_idu_rf_pipe4_vld       = 1'b1;
            idu_idu_rf_pipe4_iid       = e_iid[sel_idx];
            idu_idu_rf_pipe4_opcode    = e_opcode[sel_idx];
            idu_idu_rf_pipe4_psrc1_vld = e_psrc1_vld[sel_idx];
            idu_idu_rf_pipe4_psrc1     = e_psrc1[sel_idx];
            idu_idu_rf_pipe4_imm_vld   = e_imm_vld[sel_idx];
            idu_idu_rf_pipe4_imm       = e_imm[sel_idx];
        end
    end

    // Dispatch into a full queue is dropped by the datapath; flag it in simulation.
    assert property (@(posedge clk) disable iff (!rst_clk)
                     !(dis_pipe4_vld && iq_pipe4_full && !rtu_global_flush))
        else $warning("iq_pipe4: dispatch while full was dropped");

endmodule
